// File: rtl/cache_controller.sv
// Sequencer between a CPU load/store port, a direct-mapped cache datapath and a line-wide memory port.
// Define CACHE_CTRL_STATS_EN to add saturating hit/miss/flush counter outputs.
module cache_controller #(
  parameter int BLOCK_SIZE             = 32,
  parameter int NUM_OF_BLOCKS_PER_LINE = 4,
  parameter int NUM_OF_CACHE_LINES     = 4,
  parameter int ADDRESS_SIZE           = 32,
  parameter int CACHE_LATENCY          = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic                                     req_we_i,
  input  logic [ADDRESS_SIZE-1:0]                  req_addr_i,
  input  logic [BLOCK_SIZE-1:0]                    req_wdata_i,
  output logic                                     resp_valid_o,
  output logic [BLOCK_SIZE-1:0]                    resp_rdata_o,
  output logic                                     resp_err_o,
  output logic                                     cache_rst_n_o,
  output logic                                     cache_read_o,
  output logic                                     cache_write_o,
  output logic                                     cache_read_line_o,
  output logic                                     cache_write_line_o,
  output logic [ADDRESS_SIZE-1:0]                  cache_addr_o,
  output logic [BLOCK_SIZE-1:0]                    cache_data_o,
  output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] cache_line_o,
  input  logic [BLOCK_SIZE-1:0]                    cache_data_i,
  input  logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] cache_line_i,
  input  logic [ADDRESS_SIZE-1:0]                  cache_addr_i,
  input  logic                                     cache_hit_i,
  input  logic                                     cache_read_flush_i,
  input  logic                                     cache_read_fetch_i,
  input  logic                                     cache_write_flush_i,
  input  logic                                     cache_write_fetch_i,
  output logic                                     mem_req_o,
  output logic                                     mem_we_o,
  output logic [ADDRESS_SIZE-1:0]                  mem_addr_o,
  output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] mem_wline_o,
  input  logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] mem_rline_i,
`ifdef CACHE_CTRL_STATS_EN
  output logic [31:0]                              hit_count_o,
  output logic [31:0]                              miss_count_o,
  output logic [31:0]                              flush_count_o,
`endif
  input  logic                                     mem_ack_i
);

  localparam int LINE_W   = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;
  localparam int OFFSET_W = $clog2(NUM_OF_BLOCKS_PER_LINE);
  localparam int CNT_W    = $clog2(CACHE_LATENCY + 2);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(CACHE_LATENCY - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(1);
  localparam logic [ADDRESS_SIZE-1:0] LINE_MASK =
    ~(ADDRESS_SIZE'((64'd1 << OFFSET_W) - 64'd1));

  if (NUM_OF_CACHE_LINES < 1 || CACHE_LATENCY < 1) begin : g_bad_params
    $fatal(1, "cache_controller: NUM_OF_CACHE_LINES and CACHE_LATENCY must be at least 1");
  end

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_LOOKUP, ST_WAIT_LK, ST_RD_LINE, ST_WAIT_RL,
    ST_MEM_WR, ST_MEM_RD, ST_WR_LINE, ST_WAIT_WL, ST_RESP
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          wait_cnt;
  logic                      lat_we;
  logic [ADDRESS_SIZE-1:0]   lat_addr;
  logic [BLOCK_SIZE-1:0]     lat_wdata;
  logic                      retry;
  logic [ADDRESS_SIZE-1:0]   victim_addr;
  logic [LINE_W-1:0]         victim_line;

  logic any_flush;
  logic any_fetch;
  assign any_flush = cache_read_flush_i | cache_write_flush_i;
  assign any_fetch = cache_read_fetch_i | cache_write_fetch_i;

  // Every output is registered; command pulses are raised on entry to their state and self-clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= ST_INIT;
      wait_cnt           <= '0;
      lat_we             <= 1'b0;
      lat_addr           <= '0;
      lat_wdata          <= '0;
      retry              <= 1'b0;
      victim_addr        <= '0;
      victim_line        <= '0;
      req_ready_o        <= 1'b0;
      resp_valid_o       <= 1'b0;
      resp_rdata_o       <= '0;
      resp_err_o         <= 1'b0;
      cache_rst_n_o      <= 1'b0;
      cache_read_o       <= 1'b0;
      cache_write_o      <= 1'b0;
      cache_read_line_o  <= 1'b0;
      cache_write_line_o <= 1'b0;
      cache_addr_o       <= '0;
      cache_data_o       <= '0;
      cache_line_o       <= '0;
      mem_req_o          <= 1'b0;
      mem_we_o           <= 1'b0;
      mem_addr_o         <= '0;
      mem_wline_o        <= '0;
`ifdef CACHE_CTRL_STATS_EN
      hit_count_o        <= '0;
      miss_count_o       <= '0;
      flush_count_o      <= '0;
`endif
    end else begin
      cache_read_o       <= 1'b0;
      cache_write_o      <= 1'b0;
      cache_read_line_o  <= 1'b0;
      cache_write_line_o <= 1'b0;
      resp_valid_o       <= 1'b0;
      resp_err_o         <= 1'b0;

      case (state)
        ST_INIT: begin
          if (wait_cnt == INIT_LAST) begin
            wait_cnt      <= '0;
            cache_rst_n_o <= 1'b1;
            req_ready_o   <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o   <= 1'b0;
            lat_we        <= req_we_i;
            lat_addr      <= req_addr_i;
            lat_wdata     <= req_wdata_i;
            retry         <= 1'b0;
            cache_read_o  <= ~req_we_i;
            cache_write_o <= req_we_i;
            cache_addr_o  <= req_addr_i;
            cache_data_o  <= req_wdata_i;
            state         <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          wait_cnt <= '0;
          state    <= ST_WAIT_LK;
        end

        // Flags are only meaningful in the last latency cycle; hit wins over flush, flush over fetch.
        ST_WAIT_LK: begin
          if (wait_cnt == LAT_LAST) begin
            wait_cnt <= '0;
`ifdef CACHE_CTRL_STATS_EN
            if (!retry) begin
              if (cache_hit_i) begin
                if (hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
              end else begin
                if (miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
              end
            end
`endif
            if (cache_hit_i) begin
              resp_valid_o <= 1'b1;
              if (!lat_we) resp_rdata_o <= cache_data_i;
              state <= ST_RESP;
            end else if (!retry && any_flush) begin
              cache_read_line_o <= 1'b1;
              cache_addr_o      <= lat_addr;
              state             <= ST_RD_LINE;
            end else if (!retry && any_fetch) begin
              state <= ST_MEM_RD;
            end else begin
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              state        <= ST_RESP;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_RD_LINE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT_RL;
        end

        ST_WAIT_RL: begin
          if (wait_cnt == LAT_LAST) begin
            wait_cnt    <= '0;
            victim_line <= cache_line_i;
            victim_addr <= cache_addr_i & LINE_MASK;
            state       <= ST_MEM_WR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        // Memory states raise the request one cycle after entry and hold it untouched until ack.
        ST_MEM_WR: begin
          if (!mem_req_o) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= victim_addr;
            mem_wline_o <= victim_line;
          end else if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= ST_MEM_RD;
`ifdef CACHE_CTRL_STATS_EN
            if (flush_count_o != '1) flush_count_o <= flush_count_o + 32'd1;
`endif
          end
        end

        ST_MEM_RD: begin
          if (!mem_req_o) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= lat_addr & LINE_MASK;
          end else if (mem_ack_i) begin
            mem_req_o          <= 1'b0;
            cache_write_line_o <= 1'b1;
            cache_line_o       <= mem_rline_i;
            cache_addr_o       <= lat_addr;
            state              <= ST_WR_LINE;
          end
        end

        ST_WR_LINE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT_WL;
        end

        ST_WAIT_WL: begin
          if (wait_cnt == LAT_LAST) begin
            wait_cnt      <= '0;
            retry         <= 1'b1;
            cache_read_o  <= ~lat_we;
            cache_write_o <= lat_we;
            cache_addr_o  <= lat_addr;
            cache_data_o  <= lat_wdata;
            state         <= ST_LOOKUP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          req_ready_o <= 1'b1;
          state       <= ST_IDLE;
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural direct-mapped cache (4x4 words) and line memory.
// Define CACHE_CTRL_STATS_EN to also check the statistics counters.
module tb_cache_controller;

  logic          clk_i;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [31:0]   req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          resp_valid_o;
  logic [31:0]   resp_rdata_o;
  logic          resp_err_o;
  logic          cache_rst_n_o;
  logic          cache_read_o, cache_write_o, cache_read_line_o, cache_write_line_o;
  logic [31:0]   cache_addr_o;
  logic [31:0]   cache_data_o;
  logic [127:0]  cache_line_o;
  logic [31:0]   cache_data_i;
  logic [127:0]  cache_line_i;
  logic [31:0]   cache_addr_i;
  logic          cache_hit_i, cache_read_flush_i, cache_read_fetch_i;
  logic          cache_write_flush_i, cache_write_fetch_i;
  logic          mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [127:0]  mem_wline_o;
  logic [127:0]  mem_rline_i;
  logic          mem_ack_i;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0]   hit_count_o, miss_count_o, flush_count_o;
`endif

  cache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .cache_rst_n_o(cache_rst_n_o), .cache_read_o(cache_read_o), .cache_write_o(cache_write_o),
    .cache_read_line_o(cache_read_line_o), .cache_write_line_o(cache_write_line_o),
    .cache_addr_o(cache_addr_o), .cache_data_o(cache_data_o), .cache_line_o(cache_line_o),
    .cache_data_i(cache_data_i), .cache_line_i(cache_line_i), .cache_addr_i(cache_addr_i),
    .cache_hit_i(cache_hit_i), .cache_read_flush_i(cache_read_flush_i),
    .cache_read_fetch_i(cache_read_fetch_i), .cache_write_flush_i(cache_write_flush_i),
    .cache_write_fetch_i(cache_write_fetch_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wline_o(mem_wline_o), .mem_rline_i(mem_rline_i),
`ifdef CACHE_CTRL_STATS_EN
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o), .flush_count_o(flush_count_o),
`endif
    .mem_ack_i(mem_ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int hs_cyc    = 0;
  int mem_delay = 0;
  logic cache_no_flags = 1'b0;

  // Backing memory: every line is a function of its address, except the line at 0x10.
  function automatic logic [127:0] memLine(input logic [31:0] a);
    logic [127:0] l;
    if (a == 32'h10) l = {32'h4, 32'h3, 32'h2, 32'h1};
    else for (int i = 0; i < 4; i++) l[i*32 +: 32] = 32'h1000_0000 + a + 32'(i);
    return l;
  endfunction

  int           mem_wait     = 0;
  int           mem_rd_cnt   = 0;
  int           mem_wr_cnt   = 0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wr_addr = '0;
  logic [127:0] last_wr_line = '0;

  always @(posedge clk_i) begin
    mem_ack_i <= 1'b0;
    if (mem_ack_i) begin
      mem_wait <= 0;
    end else if (mem_req_o) begin
      if (mem_wait >= mem_delay) begin
        mem_ack_i <= 1'b1;
        mem_wait  <= 0;
        if (mem_we_o) begin
          mem_wr_cnt   <= mem_wr_cnt + 1;
          last_wr_addr <= mem_addr_o;
          last_wr_line <= mem_wline_o;
        end else begin
          mem_rd_cnt   <= mem_rd_cnt + 1;
          last_rd_addr <= mem_addr_o;
          mem_rline_i  <= memLine(mem_addr_o);
        end
      end else begin
        mem_wait <= mem_wait + 1;
      end
    end else begin
      mem_wait <= 0;
    end
  end

  // Cache model: result computed at the command edge, presented one cycle later for one cycle only.
  logic [127:0] c_data  [4];
  logic [27:0]  c_tag   [4];
  logic         c_valid [4];
  logic         c_dirty [4];
  logic         s_hit, s_rflush, s_rfetch, s_wflush, s_wfetch;
  logic [31:0]  s_data, s_addr;
  logic [127:0] s_line;
  logic [1:0]   m_idx, m_off;
  logic         m_hit;
  int           wl_cnt = 0;

  always @(posedge clk_i) begin
    cache_hit_i         <= s_hit;
    cache_read_flush_i  <= s_rflush;
    cache_read_fetch_i  <= s_rfetch;
    cache_write_flush_i <= s_wflush;
    cache_write_fetch_i <= s_wfetch;
    cache_data_i        <= s_data;
    cache_line_i        <= s_line;
    cache_addr_i        <= s_addr;
    s_hit <= 1'b0; s_rflush <= 1'b0; s_rfetch <= 1'b0; s_wflush <= 1'b0; s_wfetch <= 1'b0;
    m_idx = cache_addr_o[3:2];
    m_off = cache_addr_o[1:0];
    if (cache_rst_n_o !== 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        c_valid[i] <= 1'b0;
        c_dirty[i] <= 1'b0;
      end
    end else if (cache_read_o || cache_write_o) begin
      m_hit = c_valid[m_idx] && (c_tag[m_idx] == cache_addr_o[31:4]);
      if (cache_no_flags) begin
      end else if (m_hit) begin
        s_hit <= 1'b1;
        if (cache_read_o) begin
          s_data <= c_data[m_idx][m_off*32 +: 32];
        end else begin
          c_data[m_idx][m_off*32 +: 32] <= cache_data_o;
          c_dirty[m_idx] <= 1'b1;
        end
      end else if (c_valid[m_idx] && c_dirty[m_idx]) begin
        if (cache_read_o) s_rflush <= 1'b1; else s_wflush <= 1'b1;
      end else begin
        if (cache_read_o) s_rfetch <= 1'b1; else s_wfetch <= 1'b1;
      end
    end else if (cache_read_line_o) begin
      s_line <= c_data[m_idx];
      s_addr <= {c_tag[m_idx], m_idx, 2'b00};
    end else if (cache_write_line_o) begin
      c_data[m_idx]  <= cache_line_o;
      c_tag[m_idx]   <= cache_addr_o[31:4];
      c_valid[m_idx] <= 1'b1;
      c_dirty[m_idx] <= 1'b0;
      wl_cnt         <= wl_cnt + 1;
    end
  end

  // Protocol monitor: memory request stability, request run length, command one-hotness, responses.
  logic         prev_req = 1'b0;
  logic [31:0]  ref_addr;
  logic         ref_we;
  logic [127:0] ref_line;
  int cur_run = 0, last_run = 0, stab_err = 0, onehot_err = 0, resp_cnt = 0;

  always @(negedge clk_i) begin
    if (mem_req_o) begin
      if (!prev_req) begin
        ref_addr <= mem_addr_o; ref_we <= mem_we_o; ref_line <= mem_wline_o;
        cur_run  <= 1;
      end else begin
        if (mem_addr_o !== ref_addr || mem_we_o !== ref_we || mem_wline_o !== ref_line)
          stab_err <= stab_err + 1;
        cur_run <= cur_run + 1;
      end
    end else if (prev_req) begin
      last_run <= cur_run;
    end
    prev_req <= mem_req_o;
    if (32'(cache_read_o) + 32'(cache_write_o) + 32'(cache_read_line_o) + 32'(cache_write_line_o) > 1)
      onehot_err <= onehot_err + 1;
    if (resp_valid_o === 1'b1) resp_cnt <= resp_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total_cnt++;
    assert (observed === expected) else begin
      bad_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one request and returns at the negedge after the handshake edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int guard = 0;
    @(negedge clk_i);
    while (req_ready_o !== 1'b1 && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("ready_before_req", 128'(req_ready_o), 128'(1));
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    hs_cyc      = cyc;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic waitResponse(input string tag, output logic [31:0] rdata, output logic err,
                              output int lat);
    int guard = 0;
    int busy_ready = 0;
    while (resp_valid_o !== 1'b1 && guard < 300) begin
      if (req_ready_o !== 1'b0) busy_ready++;
      @(negedge clk_i);
      guard++;
    end
    checkOutput({tag, "_resp_seen"}, 128'(resp_valid_o), 128'(1));
    checkOutput({tag, "_ready_busy"}, 128'(busy_ready), 128'(0));
    checkOutput({tag, "_ready_at_resp"}, 128'(req_ready_o), 128'(0));
    rdata = resp_rdata_o;
    err   = resp_err_o;
    lat   = cyc - hs_cyc;
    @(negedge clk_i);
    checkOutput({tag, "_ready_after"}, 128'(req_ready_o), 128'(1));
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          guard;
  int          resp_before;

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_ready", 128'(req_ready_o), 128'(0));
    checkOutput("rst_cache_rst_n", 128'(cache_rst_n_o), 128'(0));
    checkOutput("rst_mem_req", 128'(mem_req_o), 128'(0));
    checkOutput("rst_resp_valid", 128'(resp_valid_o), 128'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("init_ready_c2", 128'(req_ready_o), 128'(0));
    checkOutput("init_rst_n_c2", 128'(cache_rst_n_o), 128'(0));
    @(negedge clk_i);
    checkOutput("init_ready_c3", 128'(req_ready_o), 128'(1));
    checkOutput("init_rst_n_c3", 128'(cache_rst_n_o), 128'(1));

    $display("[TB] read miss 0x10");
    applyStimulus(1'b0, 32'h10, 32'h0);
    waitResponse("rd10", rd, er, lat);
    checkOutput("rd10_data", 128'(rd), 128'(32'h1));
    checkOutput("rd10_err", 128'(er), 128'(0));
    checkOutput("rd10_mem_rd", 128'(mem_rd_cnt), 128'(1));
    checkOutput("rd10_mem_rd_addr", 128'(last_rd_addr), 128'(32'h10));
    checkOutput("rd10_mem_wr", 128'(mem_wr_cnt), 128'(0));
    checkOutput("rd10_write_line", 128'(wl_cnt), 128'(1));

    $display("[TB] read hit 0x13");
    applyStimulus(1'b0, 32'h13, 32'h0);
    waitResponse("rd13", rd, er, lat);
    checkOutput("rd13_data", 128'(rd), 128'(32'h4));
    checkOutput("rd13_latency", 128'(lat), 128'(4));
    checkOutput("rd13_mem_rd", 128'(mem_rd_cnt), 128'(1));

    $display("[TB] write hit 0x12, then conflicting read 0x50");
    applyStimulus(1'b1, 32'h12, 32'hDEADBEEF);
    waitResponse("wr12", rd, er, lat);
    checkOutput("wr12_err", 128'(er), 128'(0));
    checkOutput("wr12_rdata_held", 128'(rd), 128'(32'h4));
    checkOutput("wr12_latency", 128'(lat), 128'(4));
    checkOutput("wr12_mem_wr", 128'(mem_wr_cnt), 128'(0));
    applyStimulus(1'b0, 32'h50, 32'h0);
    waitResponse("rd50", rd, er, lat);
    checkOutput("rd50_mem_wr", 128'(mem_wr_cnt), 128'(1));
    checkOutput("rd50_wr_addr", 128'(last_wr_addr), 128'(32'h10));
    checkOutput("rd50_wr_line", last_wr_line, {32'h4, 32'hDEADBEEF, 32'h2, 32'h1});
    checkOutput("rd50_mem_rd", 128'(mem_rd_cnt), 128'(2));
    checkOutput("rd50_rd_addr", 128'(last_rd_addr), 128'(32'h50));
    checkOutput("rd50_data", 128'(rd), 128'(32'h1000_0050));
    checkOutput("rd50_err", 128'(er), 128'(0));

    $display("[TB] read miss 0x92 with slow memory");
    mem_delay = 10;
    applyStimulus(1'b0, 32'h92, 32'h0);
    waitResponse("rd92", rd, er, lat);
    checkOutput("rd92_data", 128'(rd), 128'(32'h1000_0092));
    checkOutput("rd92_rd_addr", 128'(last_rd_addr), 128'(32'h90));
    checkOutput("rd92_req_held_10", 128'(last_run >= 10), 128'(1));
    checkOutput("mem_stable", 128'(stab_err), 128'(0));
    mem_delay = 0;

    $display("[TB] lookup without any cache flag");
    cache_no_flags = 1'b1;
    applyStimulus(1'b0, 32'h20, 32'h0);
    waitResponse("noflag", rd, er, lat);
    checkOutput("noflag_err", 128'(er), 128'(1));
    checkOutput("noflag_rdata_held", 128'(rd), 128'(32'h1000_0092));
    checkOutput("noflag_mem_rd", 128'(mem_rd_cnt), 128'(3));
    cache_no_flags = 1'b0;
`ifdef CACHE_CTRL_STATS_EN
    checkOutput("stats_hit", 128'(hit_count_o), 128'(2));
    checkOutput("stats_miss", 128'(miss_count_o), 128'(4));
    checkOutput("stats_flush", 128'(flush_count_o), 128'(1));
`endif

    $display("[TB] reset during memory read");
    mem_delay = 40;
    applyStimulus(1'b0, 32'hA0, 32'h0);
    guard = 0;
    while (mem_req_o !== 1'b1 && guard < 60) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("abort_req_seen", 128'(mem_req_o), 128'(1));
    resp_before = resp_cnt;
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("abort_mem_req", 128'(mem_req_o), 128'(0));
    checkOutput("abort_resp_valid", 128'(resp_valid_o), 128'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort_ready_c2", 128'(req_ready_o), 128'(0));
    @(negedge clk_i);
    checkOutput("abort_ready_c3", 128'(req_ready_o), 128'(1));
    repeat (50) @(negedge clk_i);
    checkOutput("abort_no_resp", 128'(resp_cnt), 128'(resp_before));
    checkOutput("abort_idle_no_req", 128'(mem_req_o), 128'(0));
    checkOutput("cmd_onehot", 128'(onehot_err), 128'(0));
`ifdef CACHE_CTRL_STATS_EN
    checkOutput("stats_cleared", 128'(hit_count_o), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
Sequencer between a single CPU load/store port, the direct-mapped cache datapath and a line-wide backing-memory port.
- Issues read/write lookups to the cache and interprets its hit/flush/fetch flags.
- On a miss, runs dirty-line writeback (flush) and line refill (fetch), then retries the lookup.
- Returns one response per accepted request; one request is outstanding at a time.

Parameters:
BLOCK_SIZE, 32, bits per data block (word).
NUM_OF_BLOCKS_PER_LINE, 4, blocks per cache line; OFFSET_W = clog2 of this.
NUM_OF_CACHE_LINES, 4, cache lines; must match the cache instance.
ADDRESS_SIZE, 32, block-address width.
CACHE_LATENCY, 2, cycles from a cache command cycle until the cache flags/data are valid.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  CPU request valid
req_ready_o  out  1  controller can accept; high only in IDLE
req_we_i  in  1  1 = write, 0 = read
req_addr_i  in  ADDRESS_SIZE  block address
req_wdata_i  in  BLOCK_SIZE  write data
resp_valid_o  out  1  one-cycle response pulse
resp_rdata_o  out  BLOCK_SIZE  read data (held until next response)
resp_err_o  out  1  qualifies resp_valid_o; protocol/retry failure
cache_rst_n_o  out  1  active-low reset to cache
cache_read_o / cache_write_o / cache_read_line_o / cache_write_line_o  out  1 each  one-cycle cache commands
cache_addr_o  out  ADDRESS_SIZE  cache address
cache_data_o  out  BLOCK_SIZE  word write data
cache_line_o  out  NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE  refill line
cache_data_i  in  BLOCK_SIZE  cache read word
cache_line_i  in  NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE  cache victim line
cache_addr_i  in  ADDRESS_SIZE  victim line address
cache_hit_i, cache_read_flush_i, cache_read_fetch_i, cache_write_flush_i, cache_write_fetch_i  in  1 each  cache flags
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  1 = line write (flush), 0 = line read (fetch)
mem_addr_o  out  ADDRESS_SIZE  line-aligned address
mem_wline_o  out  line width  flush data
mem_rline_i  in  line width  fetch data, valid with ack
mem_ack_i  in  1  one-cycle completion

Behaviour:
- Reset state:
  - rst_i high: all outputs 0 except cache_rst_n_o = 0; state INIT.
- INIT:
  - Holds cache_rst_n_o low for 2 cycles after rst_i falls, then goes to IDLE; req_ready_o stays low throughout.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o, latch we/addr/wdata, clear retry flag, go to LOOKUP.
- LOOKUP (1 cycle):
  - Pulse cache_read_o or cache_write_o.
  - Drive cache_addr_o = latched address and cache_data_o = latched wdata.
  - Go to WAIT_LK.
- WAIT_LK:
  - Counter runs CACHE_LATENCY cycles; flags are sampled in the last cycle. Priority: hit > flush > fetch.
  - hit: go to RESP with rdata = cache_data_i for reads, or unchanged for writes. Read-hit latency is handshake cycle T to resp_valid_o at T+CACHE_LATENCY+2 (T+4 by default).
  - read_flush or write_flush: go to RD_LINE.
  - read_fetch or write_fetch: go to MEM_RD.
  - No flag, or any miss flag with the retry flag set: go to RESP with resp_err_o = 1.
- RD_LINE (1 cycle):
  - Pulse cache_read_line_o at the latched address, then wait CACHE_LATENCY cycles.
  - Capture cache_line_i and cache_addr_i, then go to MEM_WR.
- MEM_WR:
  - mem_req_o = 1, mem_we_o = 1, mem_addr_o = captured victim address, mem_wline_o = captured line.
  - On mem_ack_i, drop mem_req_o the next cycle and go to MEM_RD.
- MEM_RD:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = latched address with low OFFSET_W bits zeroed.
  - On mem_ack_i, capture mem_rline_i and go to WR_LINE.
- WR_LINE (1 cycle):
  - Pulse cache_write_line_o with cache_line_o = captured line and cache_addr_o = latched address.
  - Wait CACHE_LATENCY cycles, set the retry flag, return to LOOKUP.
- RESP:
  - resp_valid_o pulses 1 cycle; return to IDLE. req_ready_o rises in the cycle after resp_valid_o.
- Cache commands are one-hot and single-cycle; never two in the same cycle.
- mem_req_o and mem_addr_o/mem_we_o/mem_wline_o stay stable from assertion until the ack cycle.
- mem_ack_i is ignored outside MEM_WR/MEM_RD.
- Cache flags are ignored outside the sample cycle.
- req_valid_i is ignored while not ready.
- rst_i mid-operation: abort immediately to INIT, mem_req_o low the next cycle, no response issued; a late mem_ack_i is ignored.
- Address zeroing uses OFFSET_W; when NUM_OF_BLOCKS_PER_LINE = 1, no bits are cleared.

Optional Feature:
CACHE_CTRL_STATS_EN:
- Defined: adds outputs hit_count_o, miss_count_o, flush_count_o, 32 bits each, saturating at 0xFFFFFFFF and cleared by rst_i.
  - hit_count_o increments on a first-lookup hit.
  - miss_count_o increments on a first-lookup miss.
  - flush_count_o increments on each MEM_WR ack.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read 0x10 with memory line {0x4,0x3,0x2,0x1}: one mem read at 0x10, one write_line, retry hit; resp_rdata_o = 0x1, resp_err_o = 0.
- Read 0x13 immediately after: no memory traffic; resp_rdata_o = 0x4 at handshake+4.
- Write 0x12 with 0xDEADBEEF (hit), then read 0x50:
  - mem write at 0x10 with line {0x4,0xDEADBEEF,0x2,0x1};
  - then mem read at 0x50;
  - response returns word 0 of the new line.
- Read miss with mem_ack_i delayed 10 cycles: mem_req_o and mem_addr_o stable for all 10 cycles; req_ready_o = 0 until after resp_valid_o.
- Cache model returns no flags: resp_valid_o = 1 with resp_err_o = 1; controller is back in IDLE.
- Assert rst_i during MEM_RD: mem_req_o = 0 next cycle, no resp_valid_o, req_ready_o = 1 three cycles after rst_i falls.
